// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor sequencer: one full_adder cell processes a WIDTH-bit
// add or subtract LSB first, one bit per clock, behind a start/done handshake.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic axb;

   assign axb  = a ^ b;
   assign s    = axb ^ cin;
   assign cout = (a & b) | (axb & cin);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   // One-hot so the handshake outputs come straight from state flops.
   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_RUN  = 3'b010;
   localparam logic [2:0] ST_DONE = 3'b100;

   logic [2:0]       state_reg,  state_next;
   logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
   logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
   logic [WIDTH-1:1] res_sh_reg, res_sh_next;
   logic             carry_reg,  carry_next;
   logic [CW-1:0]    cnt_reg,    cnt_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             cout_reg,   cout_next;
   logic             ovf_reg,    ovf_next;

   logic             fa_s;
   logic             fa_cout;
   logic             last_step;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] res_shift;
   logic [WIDTH-1:0] b_load;

   full_adder u_fa (
      .a    (a_sh_reg[0]),
      .b    (b_sh_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Subtraction is a + ~b + 1; the +1 enters through the initial carry.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bload
         assign b_load[gi] = b[gi] ^ sub;
      end
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_shift[gi]   = a_sh_reg[gi+1];
         assign b_shift[gi]   = b_sh_reg[gi+1];
         assign res_shift[gi] = res_sh_reg[gi+1];
      end
   endgenerate

   assign a_shift[WIDTH-1]   = 1'b0;
   assign b_shift[WIDTH-1]   = 1'b0;
   assign res_shift[WIDTH-1] = fa_s;

   assign last_step = (cnt_reg == CW'(WIDTH - 1));

   always_comb begin
      state_next  = state_reg;
      a_sh_next   = a_sh_reg;
      b_sh_next   = b_sh_reg;
      res_sh_next = res_sh_reg;
      carry_next  = carry_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      cout_next   = cout_reg;
      ovf_next    = ovf_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               a_sh_next  = a;
               b_sh_next  = b_load;
               carry_next = sub;
               cnt_next   = '0;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_next   = a_shift;
            b_sh_next   = b_shift;
            res_sh_next = res_shift[WIDTH-1:1];
            carry_next  = fa_cout;
            cnt_next    = cnt_reg + CW'(1);
            if (last_step) begin
               // carry_reg here is the carry into the MSB.
               result_next = res_shift;
               cout_next   = fa_cout;
               ovf_next    = carry_reg ^ fa_cout;
               state_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         carry_reg  <= 1'b0;
         cnt_reg    <= '0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_sh_reg   <= a_sh_next;
         b_sh_reg   <= b_sh_next;
         res_sh_reg <= res_sh_next;
         carry_reg  <= carry_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         cout_reg   <= cout_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign ready  = state_reg[0];
   assign busy   = state_reg[1];
   assign done   = state_reg[2];
   assign result = result_reg;
   assign cout   = cout_reg;
   assign ovf    = ovf_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): arithmetic vectors, handshake
// timing, back-to-back throughput, ignored start and reset abort.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (ready) break;
         tick();
      end
      chk({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   // One complete operation; done must appear right after the 8th edge past accept.
   task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vs, input logic [7:0] er, input logic ec, input logic eo);
      int lat;
      lat = 0;
      wait_ready(tag);
      a = va; b = vb; sub = vs; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~va; b = ~vb; sub = ~vs;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      chk({tag, "_result"}, 32'(result), 32'(er));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      tick();
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int done_cnt;
      int last_done;
      int gaps_bad;
      int overlap;
      int run_len;
      int runs;
      int runs_bad;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) tick();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      tick();

      run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Back-to-back with start held: accepts at cycles 1, 11, 21, 31.
      wait_ready("thru");
      a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
      done_cnt = 0; last_done = -1; gaps_bad = 0; overlap = 0;
      run_len = 0; runs = 0; runs_bad = 0;
      for (int c = 1; c <= 35; c++) begin
         tick();
         if (ready && busy) overlap++;
         if (done) begin
            if (last_done >= 0 && (c - last_done) != 10) gaps_bad++;
            last_done = c;
            done_cnt++;
         end
         if (busy) begin
            run_len++;
         end else if (run_len > 0) begin
            runs++;
            if (run_len != 8) runs_bad++;
            run_len = 0;
         end
      end
      start = 1'b0;
      chk("thru_done_count", 32'(done_cnt), 32'd3);
      chk("thru_done_gap_errs", 32'(gaps_bad), 32'd0);
      chk("thru_ready_busy_overlap", 32'(overlap), 32'd0);
      chk("thru_busy_runs", 32'(runs), 32'd3);
      chk("thru_busy_len_errs", 32'(runs_bad), 32'd0);
      chk("thru_result", 32'(result), 32'h46);
      wait_ready("thru_end");

      // Extra start and operand change while running must be ignored.
      a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      a = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("ign_done_count", 32'(done_cnt), 32'd1);
      chk("ign_result", 32'(result), 32'h02);
      chk("ign_cout", 32'(cout), 32'd0);
      chk("ign_ready", 32'(ready), 32'd1);

      // Reset in the 4th RUN cycle aborts the operation.
      a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done || busy) done_cnt++;
      end
      chk("abort_no_activity", 32'(done_cnt), 32'd0);
      run_op("after_abort", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
